// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and round-robin pick helper for mem_port_arbiter
package mem_arb_pkg;

   localparam int NUM_CLIENTS = 2;
   localparam int CLIENT0     = 0;
   localparam int CLIENT1     = 1;

   // One-hot grant from a 2-bit request; ptr names the favoured client on a tie.
   function automatic logic [NUM_CLIENTS-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                      input logic                   ptr);
      logic [NUM_CLIENTS-1:0] gnt;
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
      return gnt;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - 2-way round-robin grant with masked candidates
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [NUM_CLIENTS-1:0] mask,
   output logic [NUM_CLIENTS-1:0] gnt
);

   logic ptr;

   // Grants are forced low while reset is held so nothing reaches the RAM.
   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         gnt = rr_pick(req & mask, ptr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (gnt[CLIENT0]) begin
         ptr <= 1'b1;
      end else if (gnt[CLIENT1]) begin
         ptr <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares a simple-dual-port RAM between two clients
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CLIENTS-1:0]            wr_req,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data,
   output logic [NUM_CLIENTS-1:0]            wr_gnt,
   input  logic [NUM_CLIENTS-1:0]            rd_req,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_CLIENTS-1:0]            rd_gnt,
   output logic [NUM_CLIENTS-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]             rsp_data,
   output logic                              mem_write_enable,
   output logic [ADDR_WIDTH-1:0]             mem_wr_addr,
   output logic [DATA_WIDTH-1:0]             mem_data_in,
   output logic                              mem_read_enable,
   output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]             mem_data_out
);

   logic [ADDR_WIDTH-1:0]  wr_addr0, wr_addr1, rd_addr0, rd_addr1;
   logic [DATA_WIDTH-1:0]  wr_data0, wr_data1;
   logic [NUM_CLIENTS-1:0] rd_mask;

   assign wr_addr0 = wr_addr[CLIENT0*ADDR_WIDTH +: ADDR_WIDTH];
   assign wr_addr1 = wr_addr[CLIENT1*ADDR_WIDTH +: ADDR_WIDTH];
   assign wr_data0 = wr_data[CLIENT0*DATA_WIDTH +: DATA_WIDTH];
   assign wr_data1 = wr_data[CLIENT1*DATA_WIDTH +: DATA_WIDTH];
   assign rd_addr0 = rd_addr[CLIENT0*ADDR_WIDTH +: ADDR_WIDTH];
   assign rd_addr1 = rd_addr[CLIENT1*ADDR_WIDTH +: ADDR_WIDTH];

   rr_arb2 u_wr_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (wr_req),
      .mask  (2'b11),
      .gnt   (wr_gnt)
   );

   always_comb begin
      mem_write_enable = |wr_gnt;
      mem_wr_addr      = wr_gnt[CLIENT1] ? wr_addr1 : wr_addr0;
      mem_data_in      = wr_gnt[CLIENT1] ? wr_data1 : wr_data0;
   end

   // A read to the address being written this cycle would see stale RAM data.
   always_comb begin
      rd_mask          = 2'b11;
      rd_mask[CLIENT0] = !(mem_write_enable && (rd_addr0 == mem_wr_addr));
      rd_mask[CLIENT1] = !(mem_write_enable && (rd_addr1 == mem_wr_addr));
   end

   rr_arb2 u_rd_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (rd_req),
      .mask  (rd_mask),
      .gnt   (rd_gnt)
   );

   always_comb begin
      mem_read_enable = |rd_gnt;
      mem_rd_addr     = rd_gnt[CLIENT1] ? rd_addr1 : rd_addr0;
      rsp_data        = mem_data_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
      end else begin
         rsp_valid <= rd_gnt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int DW = 8;
   localparam int AW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      wr_req, rd_req;
   logic [2*AW-1:0] wr_addr, rd_addr;
   logic [2*DW-1:0] wr_data;
   logic [1:0]      wr_gnt, rd_gnt, rsp_valid;
   logic [DW-1:0]   rsp_data, mem_data_in, mem_data_out;
   logic            mem_write_enable, mem_read_enable;
   logic [AW-1:0]   mem_wr_addr, mem_rd_addr;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] ram [256];
   logic [DW-1:0] ref_mem [256];
   bit            ref_known [256];

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .wr_req           (wr_req),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .wr_gnt           (wr_gnt),
      .rd_req           (rd_req),
      .rd_addr          (rd_addr),
      .rd_gnt           (rd_gnt),
      .rsp_valid        (rsp_valid),
      .rsp_data         (rsp_data),
      .mem_write_enable (mem_write_enable),
      .mem_wr_addr      (mem_wr_addr),
      .mem_data_in      (mem_data_in),
      .mem_read_enable  (mem_read_enable),
      .mem_rd_addr      (mem_rd_addr),
      .mem_data_out     (mem_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_enable) ram[mem_wr_addr] <= mem_data_in;
      if (mem_read_enable) mem_data_out <= ram[mem_rd_addr];
   end

   function automatic int pick2(bit c0, bit c1, int ptr);
      if (c0 && c1) return ptr;
      if (c0) return 0;
      if (c1) return 1;
      return -1;
   endfunction

   task automatic clear_inputs();
      wr_req = 2'b00; rd_req = 2'b00;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_req = 2'b11; rd_req = 2'b11;
      wr_addr = {8'h20, 8'h10}; wr_data = {8'h02, 8'h01};
      rd_addr = {8'h31, 8'h30};
      @(negedge clk);
      tests++; if (wr_gnt !== 2'b00) begin fails++; $display("FAIL reset_wr_gnt got %b want 00", wr_gnt); end
      tests++; if (rd_gnt !== 2'b00) begin fails++; $display("FAIL reset_rd_gnt got %b want 00", rd_gnt); end
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
      tests++; if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin
         fails++; $display("FAIL reset_mem_en got we=%b re=%b want 0 0", mem_write_enable, mem_read_enable);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      #1;
      tests++; if (wr_gnt !== 2'b01) begin fails++; $display("FAIL release_wr_gnt got %b want 01", wr_gnt); end
      tests++; if (rd_gnt !== 2'b01) begin fails++; $display("FAIL release_rd_gnt got %b want 01", rd_gnt); end
      @(posedge clk); #1;
      clear_inputs();
      tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL release_rsp_valid got %b want 01", rsp_valid); end
   endtask

   task automatic test_write_contention();
      logic [1:0] exp;
      apply_reset();
      wr_req = 2'b11;
      wr_addr = {8'h20, 8'h10};
      wr_data = {8'hA5, 8'h3C};
      for (int k = 0; k < 4; k++) begin
         exp = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         tests++; if (wr_gnt !== exp) begin fails++; $display("FAIL contention_gnt[%0d] got %b want %b", k, wr_gnt, exp); end
         tests++; if (mem_wr_addr !== ((k % 2 == 0) ? 8'h10 : 8'h20)) begin
            fails++; $display("FAIL contention_addr[%0d] got %h", k, mem_wr_addr);
         end
         @(posedge clk); #1;
      end
      wr_req = 2'b00;
      tests++; if (ram[8'h10] !== 8'h3C || ram[8'h20] !== 8'hA5) begin
         fails++; $display("FAIL contention_ram got %h %h want 3c a5", ram[8'h10], ram[8'h20]);
      end
   endtask

   task automatic test_read_latency();
      rd_req = 2'b10; rd_addr = {8'h20, 8'h10};
      #1;
      tests++; if (rd_gnt !== 2'b10) begin fails++; $display("FAIL latency_gnt got %b want 10", rd_gnt); end
      tests++; if (mem_rd_addr !== 8'h20) begin fails++; $display("FAIL latency_rd_addr got %h want 20", mem_rd_addr); end
      @(posedge clk); #1;
      rd_req = 2'b01;
      tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL latency_rsp_valid got %b want 10", rsp_valid); end
      tests++; if (rsp_data !== 8'hA5) begin fails++; $display("FAIL latency_rsp_data got %h want a5", rsp_data); end
      @(posedge clk); #1;
      rd_req = 2'b00;
      tests++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h3C) begin
         fails++; $display("FAIL b2b_rsp got %b/%h want 01/3c", rsp_valid, rsp_data);
      end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL idle_rsp_valid got %b want 00", rsp_valid); end
   endtask

   task automatic test_hazard();
      apply_reset();
      wr_req = 2'b01; wr_addr = {8'h00, 8'h40}; wr_data = {8'h00, 8'h33};
      rd_req = 2'b10; rd_addr = {8'h40, 8'h00};
      #1;
      tests++; if (wr_gnt !== 2'b01) begin fails++; $display("FAIL hazard_wr_gnt got %b want 01", wr_gnt); end
      tests++; if (rd_gnt !== 2'b00) begin fails++; $display("FAIL hazard_rd_blocked got %b want 00", rd_gnt); end
      @(posedge clk); #1;
      wr_req = 2'b00;
      #1;
      tests++; if (rd_gnt !== 2'b10) begin fails++; $display("FAIL hazard_rd_retry got %b want 10", rd_gnt); end
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL hazard_no_rsp got %b want 00", rsp_valid); end
      @(posedge clk); #1;
      rd_req = 2'b00;
      tests++; if (rsp_valid !== 2'b10 || rsp_data !== 8'h33) begin
         fails++; $display("FAIL hazard_rsp got %b/%h want 10/33", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_hazard_bypass();
      apply_reset();
      wr_req = 2'b01; wr_addr = {8'h00, 8'h40}; wr_data = {8'h00, 8'h55};
      rd_req = 2'b11; rd_addr = {8'h40, 8'h41};
      #1;
      tests++; if (rd_gnt !== 2'b01) begin fails++; $display("FAIL bypass_rd_gnt got %b want 01", rd_gnt); end
      @(posedge clk); #1;
      wr_req = 2'b00;
      #1;
      tests++; if (rd_gnt !== 2'b10) begin fails++; $display("FAIL bypass_ptr_moved got %b want 10", rd_gnt); end
      @(posedge clk); #1;
      rd_req = 2'b00;
      tests++; if (rsp_valid !== 2'b10 || rsp_data !== 8'h55) begin
         fails++; $display("FAIL bypass_rsp got %b/%h want 10/55", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_midflight_reset();
      apply_reset();
      rd_req = 2'b01; rd_addr = {8'h20, 8'h10};
      #1;
      tests++; if (rd_gnt !== 2'b01) begin fails++; $display("FAIL mid_rd_gnt got %b want 01", rd_gnt); end
      @(posedge clk); #1;
      rd_req = 2'b00;
      tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL mid_rsp_before got %b want 01", rsp_valid); end
      rst_n = 1'b0;
      #1;
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL mid_rsp_dropped got %b want 00", rsp_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_req = 2'b11;
      #1;
      tests++; if (rd_gnt !== 2'b01) begin fails++; $display("FAIL mid_ptr_reset got %b want 01", rd_gnt); end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_random();
      bit            wp [2], rp [2];
      logic [AW-1:0] wa [2], ra [2];
      logic [DW-1:0] wd [2];
      int            m_wp, m_rp, gw, gr;
      logic [1:0]    ew, er, exp_rv;
      logic [DW-1:0] exp_rd;
      bit            exp_known;
      apply_reset();
      for (int a = 0; a < 256; a++) ref_known[a] = 1'b0;
      for (int i = 0; i < 2; i++) begin wp[i] = 0; rp[i] = 0; wa[i] = '0; ra[i] = '0; wd[i] = '0; end
      m_wp = 0; m_rp = 0; exp_rv = 2'b00; exp_rd = '0; exp_known = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         tests++; if (rsp_valid !== exp_rv) begin
            fails++; $display("FAIL rand_rsp_valid cyc %0d got %b want %b", cyc, rsp_valid, exp_rv);
         end
         if (exp_rv != 2'b00 && exp_known) begin
            tests++; if (rsp_data !== exp_rd) begin
               fails++; $display("FAIL rand_rsp_data cyc %0d got %h want %h", cyc, rsp_data, exp_rd);
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (!wp[i] && ($urandom % 3 != 0)) begin
               wp[i] = 1; wa[i] = AW'($urandom % 8); wd[i] = DW'($urandom);
            end
            if (!rp[i] && ($urandom % 3 != 0)) begin
               rp[i] = 1; ra[i] = AW'($urandom % 8);
            end
         end
         wr_req = {wp[1], wp[0]}; rd_req = {rp[1], rp[0]};
         wr_addr = {wa[1], wa[0]}; wr_data = {wd[1], wd[0]}; rd_addr = {ra[1], ra[0]};
         gw = pick2(wp[0], wp[1], m_wp);
         gr = pick2(rp[0] && !(gw >= 0 && ra[0] == wa[gw]),
                    rp[1] && !(gw >= 0 && ra[1] == wa[gw]), m_rp);
         ew = 2'b00; if (gw >= 0) ew[gw] = 1'b1;
         er = 2'b00; if (gr >= 0) er[gr] = 1'b1;
         #1;
         tests++; if (wr_gnt !== ew) begin fails++; $display("FAIL rand_wr_gnt cyc %0d got %b want %b", cyc, wr_gnt, ew); end
         tests++; if (rd_gnt !== er) begin fails++; $display("FAIL rand_rd_gnt cyc %0d got %b want %b", cyc, rd_gnt, er); end
         if (gw >= 0) begin
            tests++; if (mem_wr_addr !== wa[gw] || mem_data_in !== wd[gw]) begin
               fails++; $display("FAIL rand_wr_bus cyc %0d got %h/%h want %h/%h", cyc, mem_wr_addr, mem_data_in, wa[gw], wd[gw]);
            end
         end
         exp_rv = er;
         if (gr >= 0) begin
            exp_rd = ref_mem[ra[gr]]; exp_known = ref_known[ra[gr]];
            m_rp = 1 - gr; rp[gr] = 0;
         end
         if (gw >= 0) begin
            ref_mem[wa[gw]] = wd[gw]; ref_known[wa[gw]] = 1'b1;
            m_wp = 1 - gw; wp[gw] = 0;
         end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_write_contention();
      test_read_latency();
      test_hazard();
      test_hazard_bypass();
      test_midflight_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
